// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit for the EX stage.
// It runs MULT/MULTU/DIV/DIVU one bit per cycle and writes the HI/LO registers.
// A single 64-bit register serves both operations:
//   multiply - {partial product, multiplier}, shifted right each step
//   divide   - {remainder, dividend/quotient}, shifted left each step
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] DataBus_A,
    input  logic [31:0] DataBus_B,
    input  logic        rd_req,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        md_stall
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_op;
    logic [31:0] r_opnd;      // multiplicand (mult) or divisor (div), as a magnitude
    logic [31:0] r_raw_a;     // raw rs value, returned in HI on divide by zero
    logic        r_sign_a;
    logic        r_sign_b;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_in_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_add;
    logic [63:0] w_mul_next;
    logic [33:0] w_trial;
    logic [63:0] w_div_next;
    logic        w_signed;
    logic        w_is_div;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Operand magnitudes at issue; MULTU/DIVU take the operands as they are.
    always_comb begin
        w_in_signed = ~op[0];
        w_mag_a     = (w_in_signed && DataBus_A[31]) ? (~DataBus_A + 32'd1) : DataBus_A;
        w_mag_b     = (w_in_signed && DataBus_B[31]) ? (~DataBus_B + 32'd1) : DataBus_B;
    end

    // One iteration step for each operation, plus the sign-corrected results.
    always_comb begin
        w_signed   = ~r_op[0];
        w_is_div   = r_op[1];
        // Shift-add: add the multiplicand into the upper half when the multiplier LSB is set.
        w_add      = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
        w_mul_next = {w_add, r_acc[31:1]};
        // Restoring step: shift in the next dividend bit and try to subtract the divisor.
        w_trial    = {1'b0, r_acc[63:32], r_acc[31]} - {2'b00, r_opnd};
        w_div_next = w_trial[33] ? {r_acc[62:0], 1'b0}
                                 : {w_trial[31:0], r_acc[30:0], 1'b1};
        // 0x8000_0000 / -1 needs no special case: the quotient magnitude 2^31
        // negated is 0x8000_0000 again, and the remainder is 0.
        w_prod     = (w_signed && (r_sign_a ^ r_sign_b)) ? (~r_acc + 64'd1) : r_acc;
        w_quot     = (w_signed && (r_sign_a ^ r_sign_b)) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        w_rem      = (w_signed && r_sign_a) ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    end

    // Next-state logic: RUN lasts 32 iterations, and FIX always returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == 6'd31) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register. Reset aborts any operation and suppresses its done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_FIX);
        end
    end

    // Datapath: operand latch, iteration, and HI/LO writeback or idle moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= 2'b00;
            r_opnd   <= 32'd0;
            r_raw_a  <= 32'd0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_raw_a  <= DataBus_A;
                        r_sign_a <= w_in_signed & DataBus_A[31];
                        r_sign_b <= w_in_signed & DataBus_B[31];
                        r_cnt    <= 6'd0;
                        r_opnd   <= op[1] ? w_mag_b : w_mag_a;
                        r_acc    <= {32'd0, (op[1] ? w_mag_a : w_mag_b)};
                    end else begin
                        if (mthi) r_hi <= DataBus_A;
                        if (mtlo) r_lo <= DataBus_A;
                    end
                end
                S_RUN: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIX: begin
                    if (!w_is_div) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end else if (r_opnd == 32'd0) begin
                        r_hi <= r_raw_a;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI       = r_hi;
    assign LO       = r_lo;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign md_stall = busy & (start | rd_req | mthi | mtlo);

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: a table of directed vectors, hand-written stall, move
// and reset sequences, and random operations checked against an arithmetic model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset, start, rd_req, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] DataBus_A, DataBus_B;
    logic [31:0] HI, LO;
    logic        busy, done, md_stall;

    int checks = 0;
    int errors = 0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .DataBus_A(DataBus_A), .DataBus_B(DataBus_B),
        .rd_req(rd_req), .mthi(mthi), .mtlo(mtlo),
        .HI(HI), .LO(LO), .busy(busy), .done(done), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     ia, ib;
        logic [63:0] ua, ub;
        ref_md = 64'd0;
        case (o)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                ref_md = sa * sb;
            end
            2'b01: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                ref_md = ua * ub;
            end
            2'b10: begin
                ia = $signed(a);
                ib = $signed(b);
                if (b == 32'd0) ref_md = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_md = {32'd0, 32'h8000_0000};
                else ref_md = {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 32'd0) ref_md = {a, 32'hFFFF_FFFF};
                else ref_md = {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one operation at the next edge (edge k). Returns HI/LO when done is
    // first seen, the number of edges after k until then, and the busy cycles seen.
    task automatic run_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; DataBus_A = a; DataBus_B = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        hi = HI;
        lo = LO;
    endtask

    logic [31:0] hi_r, lo_r;
    logic [63:0] exp64;
    int lat, bcnt, bad, dcnt;
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    initial begin
        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[6] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

        reset = 1'b1; start = 1'b0; rd_req = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; DataBus_A = 32'd0; DataBus_B = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", {32'd0, HI}, 64'd0);
        chk("reset_lo", {32'd0, LO}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk); reset = 1'b0;

        // Idle moves: both at once, visible after the edge.
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; DataBus_A = 32'h0000_CAFE;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        chk("idle_mthi", {32'd0, HI}, 64'h0000_CAFE);
        chk("idle_mtlo", {32'd0, LO}, 64'h0000_CAFE);

        // Directed vectors, with latency, busy length and done pulse width.
        for (int i = 0; i < 8; i++) begin
            run_md(vecs[i].op, vecs[i].a, vecs[i].b, hi_r, lo_r, lat, bcnt);
            chk($sformatf("vec%0d_hi", i), {32'd0, hi_r}, {32'd0, vecs[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, lo_r}, {32'd0, vecs[i].lo});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd33);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
        end

        // start wins over mthi in the same cycle; mthi stays ignored while busy.
        mthi = 1'b1;
        run_md(2'b01, 32'd9, 32'd11, hi_r, lo_r, lat, bcnt);
        mthi = 1'b0;
        chk("prio_hi", {32'd0, hi_r}, 64'd0);
        chk("prio_lo", {32'd0, lo_r}, 64'd99);

        // Stall: rd_req and mtlo held from the cycle after issue.
        @(negedge clk); start = 1'b1; op = 2'b01; DataBus_A = 32'd3; DataBus_B = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; rd_req = 1'b1; mtlo = 1'b1; DataBus_A = 32'h0000_1234;
        bad = 0; lat = 0;
        #1;
        while (!done && lat < 100) begin
            if (md_stall !== busy || busy !== 1'b1) bad++;
            @(posedge clk); #1;
            lat++;
            #1;
        end
        chk("stall_while_busy", 64'(bad), 64'd0);
        chk("stall_latency", 64'(lat), 64'd33);
        chk("stall_drops_at_done", {63'd0, md_stall}, 64'd0);
        chk("mtlo_ignored_busy", {32'd0, LO}, 64'd12);
        @(posedge clk); #1;
        chk("mtlo_idle", {32'd0, LO}, 64'h0000_1234);
        rd_req = 1'b0; mtlo = 1'b0;

        // Reset in mid-operation.
        @(negedge clk); start = 1'b1; op = 2'b01; DataBus_A = 32'd5; DataBus_B = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_hilo", {HI, LO}, 64'd0);
        @(negedge clk); reset = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("midreset_no_done", 64'(dcnt), 64'd0);
        run_md(2'b01, 32'd5, 32'd6, hi_r, lo_r, lat, bcnt);
        chk("after_reset_mul", {hi_r, lo_r}, 64'd30);

        // Random operations against the model, with some corner operands mixed in.
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin ra = $urandom_range(0, 300); rb = $urandom_range(0, 20); end
                1: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd0; end
                2: begin ra = $urandom; rb = 32'(-$signed(32'($urandom_range(1, 9)))); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            exp64 = ref_md(rop, ra, rb);
            run_md(rop, ra, rb, hi_r, lo_r, lat, bcnt);
            checks++;
            if ({hi_r, lo_r} !== exp64 || lat != 33) begin
                errors++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: got %h lat %0d expected %h lat 33",
                         n, rop, ra, rb, {hi_r, lo_r}, lat, exp64);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit for the EX stage of the five-stage pipeline. It consumes the operand buses and control fields latched by the ID/EX pipeline register and executes MULT, MULTU, DIV and DIVU over multiple cycles. Results go into architectural HI/LO registers. It drives a stall request to the hazard logic while a HI/LO access or a new multiply/divide would collide with an operation still in progress.

## Interface

- No parameters.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  a mult/div instruction occupies EX this cycle.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `DataBus_A`  in  32  rs operand (already forwarded).
- `DataBus_B`  in  32  rt operand (already forwarded).
- `rd_req`  in  1  MFHI/MFLO occupies EX this cycle.
- `mthi`  in  1  MTHI occupies EX this cycle.
- `mtlo`  in  1  MTLO occupies EX this cycle.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO were updated on the preceding edge.
- `md_stall`  out  1  combinational stall request to the hazard unit.

## Operation

- States: IDLE, RUN, FIX.
- **IDLE, `start`=1 at edge k:**
  - Latch `op`.
  - Latch operand magnitudes: two's-complement absolute value if signed op and bit 31 is set, raw value otherwise.
  - Latch sign flags and the raw dividend sign.
  - Clear the 6-bit counter; go to RUN.
- **IDLE, `start`=0:**
  - `mthi`=1 writes `DataBus_A` to HI.
  - `mtlo`=1 writes `DataBus_A` to LO.
  - Both may be asserted in the same cycle.
  - `start` has priority over `mthi`/`mtlo` in the same cycle; the moves are ignored.
- **RUN, multiply:**
  - Radix-2 shift-add into a 64-bit accumulator, one bit per cycle.
  - 32 iterations.
- **RUN, divide:**
  - Restoring division: 32-bit remainder, 32-bit quotient.
  - One bit per cycle, 32 iterations.
- **RUN exit:** counter reaching 31 moves to FIX at the same edge.
- **FIX, sign correction:**
  - Signed multiply: negate the 64-bit product if operand signs differ.
  - Signed divide: negate the quotient if signs differ; negate the remainder if the dividend was negative.
- **FIX, writeback:** HI = upper product / remainder; LO = lower product / quotient. Go to IDLE.
- **Divide by zero:** completes with normal latency; LO = 32'hFFFF_FFFF, HI = `DataBus_A` as latched (raw), no sign fix.
- **Signed overflow** (0x8000_0000 / −1): LO = 0x8000_0000, HI = 0.
- `busy` = (state != IDLE).
- `md_stall` = `busy` & (`start` | `rd_req` | `mthi` | `mtlo`).
- While `busy`, `start`/`mthi`/`mtlo` are ignored; the hazard unit holds the instruction in EX until `md_stall` falls.
- `HI`/`LO` outputs are direct register values; unchanged until FIX or an idle move.

## Timing

- Reset values: state IDLE, `HI`=0, `LO`=0, `busy`=0, `done`=0, counter=0.
- Reset mid-operation aborts immediately. HI/LO are cleared to 0 and no `done` is produced.
- `start` sampled at edge k:
  - RUN occupies edges k+1 … k+32.
  - FIX writes HI/LO at edge k+33.
  - `done`=1 in cycle k+33..k+34.
  - `busy`=1 from after edge k until edge k+33.
- Total latency 33 cycles; issue interval 34 cycles minimum. A new `start` is accepted at edge k+34 at the earliest.
- `rd_req` in the cycle where `done`=1 is not stalled and sees the new HI/LO.
- `mthi`/`mtlo` in IDLE take effect at that edge; visible the next cycle.

## Test plan

- **MULTU** A=0xFFFF_FFFF, B=0xFFFF_FFFF, `start` at edge k → at edge k+33 HI=0xFFFF_FFFE, LO=0x0000_0001; `done` one cycle; `busy` 33 cycles.
- **MULT** A=0xFFFF_FFFD (−3), B=7 → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB (−21).
- **DIV** A=0xFFFF_FFF9 (−7), B=2 → LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1).
- **DIVU** A=100, B=0 → LO=0xFFFF_FFFF, HI=100.
- **DIVU** A=100, B=7 → LO=14, HI=2.
- **Stall and moves:**
  - `rd_req` held from edge k+1 → `md_stall`=1 every busy cycle; falls when `done`=1.
  - `mtlo` with A=0x1234 while busy → LO unchanged by the move.
  - The same `mtlo` in IDLE → LO=0x1234 next cycle.
- **Reset mid-op:** `start` MULTU 5×6, `reset` at edge k+10 → `busy`=0, HI=LO=0, no `done`. A following MULTU 5×6 gives LO=30, HI=0.
